axi_wr_burst_arbiter: RTL and testbench
=======================================

// Module: axi_wr_burst_arbiter
// PURPOSE
//  Write-path scheduler for one shared slave port in the 3-master AXI interconnect.
//  Arbitrates master AW requests, then locks the grant across the whole transaction: AW, all W beats, B.
//  Drives the one-hot grant that steers the AW/W/B muxes, plus per-phase enables that gate slave-side valid/ready.
//  Sits between the master-side request inputs and the m2s datapath muxes.
// PARAMETERS
//  NUM          3     number of masters; the logic is written for exactly 3
//  TIMEOUT_CYC  256   watchdog limit in cycles without handshake progress (used only with WR_WATCHDOG_EN)
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous reset, active-high
//  arbiter_type   in   1  0 = round robin; 1 = fixed priority (master 0 highest)
//  m_awvalid      in   3  AW request, one bit per master
//  s_awvalid      in   1  muxed AW valid at the slave port
//  s_awready      in   1  slave AW ready
//  s_wvalid       in   1  muxed W valid at the slave port
//  s_wready       in   1  slave W ready
//  s_wlast        in   1  muxed W last
//  s_bvalid       in   1  slave B valid
//  s_bready       in   1  muxed B ready from the granted master
//  grant          out  3  one-hot mux select, registered
//  aw_en          out  1  AW phase active: pass AW valid/ready
//  w_en           out  1  W phase active: pass W valid/ready
//  b_en           out  1  B phase active: pass B valid/ready
//  busy           out  1  state != IDLE
//  timeout_err    out  1  one-cycle watchdog pulse
// BEHAVIOUR
//  - Reset: state = IDLE; grant = 0; last_winner = 0; aw_en/w_en/b_en/busy/timeout_err = 0; watchdog count = 0.
//  - FSM states: IDLE -> ADDR -> DATA -> RESP -> IDLE. All outputs are decoded from registers.
//  - IDLE: if |m_awvalid, register the winner into grant and last_winner, and go to ADDR. Otherwise hold; grant = 0.
//  - arbiter_type and m_awvalid are sampled only in IDLE. Changes during a transaction have no effect.
//  - Round robin: search order starts at the master after last_winner and wraps (last=001: 1,2,0; 010: 2,0,1;
//    100: 0,1,2; 000: 0,1,2).
//  - Fixed priority: the lowest-index requester wins. last_winner is still updated.
//  - ADDR: aw_en = 1. On s_awvalid & s_awready, go to DATA.
//  - DATA: w_en = 1. On s_wvalid & s_wready & s_wlast, go to RESP. Non-last beats stay in DATA.
//  - RESP: b_en = 1. On s_bvalid & s_bready, go to IDLE; grant clears on the same edge.
//  - Exactly one of aw_en/w_en/b_en is 1 outside IDLE. W data presented before the AW handshake is held off (w_en = 0).
//  - grant holds constant from ADDR entry through RESP exit, even if the granted master drops m_awvalid.
//  - Latency: request seen in IDLE at edge N -> grant and aw_en valid after N.
//    RESP handshake at edge N -> IDLE after N -> next grant after N+1 (one idle cycle minimum).
//  - Reset mid-transaction: abort to IDLE immediately. grant = 0, last_winner = 0; no pending state is kept.
// CONFIGURATION
//  WR_WATCHDOG_EN defined:
//   - A counter runs in ADDR/DATA/RESP. It clears on state entry and on every AW, W-beat or B handshake.
//   - When it reaches TIMEOUT_CYC: timeout_err = 1 for one cycle, state -> IDLE, grant = 0. last_winner is kept.
//  WR_WATCHDOG_EN undefined: no counter; timeout_err is tied to 0; the FSM waits indefinitely.
// TESTING
//  1. Reset, then m_awvalid=001; AW handshake; 4 W beats (last on beat 4); B handshake
//     -> grant=001 for the whole transaction; aw_en, w_en, b_en each assert once in order; then back to IDLE.
//  2. arbiter_type=0, m_awvalid=111 held, 3 transactions -> grants 001, 010, 100, then 001 on the 4th.
//  3. arbiter_type=1, m_awvalid=110 then 111 -> grant=010 for the 1st, 001 for the 2nd; master 2 is never granted.
//  4. arbiter_type toggled during DATA, and m_awvalid changed from 001 to 100 mid-burst
//     -> grant stays 001 until the B handshake.
//  5. rst pulsed during DATA of a master-1 transaction, then m_awvalid=110
//     -> after reset, outputs are 0; the next grant is 010 (search order restarts at master 0).
//  6. WR_WATCHDOG_EN with TIMEOUT_CYC=8; enter DATA with s_wready=0
//     -> timeout_err pulses 8 cycles after DATA entry; state is IDLE on the next cycle.
//     Without the macro -> state stays in DATA and timeout_err stays 0.

Source files
------------

// File: rtl/axi_wr_burst_arbiter_if.sv
// Master-side request and slave-side handshake bundle for the write-burst arbiter.
// Rev 1.0 - initial release.
`default_nettype none

interface axi_wr_burst_arbiter_if #(
  parameter int NUM = 3
) ();
  logic [NUM-1:0] m_awvalid;
  logic           s_awvalid;
  logic           s_awready;
  logic           s_wvalid;
  logic           s_wready;
  logic           s_wlast;
  logic           s_bvalid;
  logic           s_bready;
  logic [NUM-1:0] grant;
  logic           aw_en;
  logic           w_en;
  logic           b_en;

  modport master (
    output m_awvalid, s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    input  grant, aw_en, w_en, b_en
  );

  modport slave (
    input  m_awvalid, s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    output grant, aw_en, w_en, b_en
  );
endinterface

`default_nettype wire

// File: rtl/axi_wr_burst_arbiter.sv
// axi_wr_burst_arbiter: 3-master write scheduler locking the grant across AW, W beats and B.
// Optional watchdog under macro WR_WATCHDOG_EN. Rev 1.0 - initial release.
`default_nettype none

module axi_wr_burst_arbiter #(
  parameter int NUM         = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          arbiter_type,
  axi_wr_burst_arbiter_if.slave bus,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t         state;
  logic [NUM-1:0] last_winner;
  logic [NUM-1:0] winner;
  logic           aw_hs;
  logic           w_hs;
  logic           b_hs;

  assign aw_hs = bus.s_awvalid & bus.s_awready;
  assign w_hs  = bus.s_wvalid & bus.s_wready;
  assign b_hs  = bus.s_bvalid & bus.s_bready;
  assign busy  = (state != IDLE);

  // Round robin starts one past the previous winner; no history behaves like master 2 last.
  always_comb begin
    winner = '0;
    if (arbiter_type) begin
      if (bus.m_awvalid[0])      winner = 3'b001;
      else if (bus.m_awvalid[1]) winner = 3'b010;
      else if (bus.m_awvalid[2]) winner = 3'b100;
    end else begin
      case (last_winner)
        3'b001: begin
          if (bus.m_awvalid[1])      winner = 3'b010;
          else if (bus.m_awvalid[2]) winner = 3'b100;
          else if (bus.m_awvalid[0]) winner = 3'b001;
        end
        3'b010: begin
          if (bus.m_awvalid[2])      winner = 3'b100;
          else if (bus.m_awvalid[0]) winner = 3'b001;
          else if (bus.m_awvalid[1]) winner = 3'b010;
        end
        default: begin
          if (bus.m_awvalid[0])      winner = 3'b001;
          else if (bus.m_awvalid[1]) winner = 3'b010;
          else if (bus.m_awvalid[2]) winner = 3'b100;
        end
      endcase
    end
  end

`ifdef WR_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            progress;

  assign progress = ((state == ADDR) & aw_hs) | ((state == DATA) & w_hs) | ((state == RESP) & b_hs);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.grant   <= '0;
      last_winner <= '0;
      bus.aw_en   <= 1'b0;
      bus.w_en    <= 1'b0;
      bus.b_en    <= 1'b0;
`ifdef WR_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.m_awvalid) begin
            bus.grant   <= winner;
            last_winner <= winner;
            bus.aw_en   <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            bus.aw_en <= 1'b0;
            bus.w_en  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs & bus.s_wlast) begin
            bus.w_en <= 1'b0;
            bus.b_en <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            bus.b_en  <= 1'b0;
            bus.grant <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef WR_WATCHDOG_EN
      // Expiry overrides any phase update above; last_winner survives the abort.
      timeout_err <= 1'b0;
      if ((state == IDLE) || progress) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt      <= '0;
        timeout_err <= 1'b1;
        state       <= IDLE;
        bus.grant   <= '0;
        bus.aw_en   <= 1'b0;
        bus.w_en    <= 1'b0;
        bus.b_en    <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_burst_arbiter.sv
// Self-checking bench for axi_wr_burst_arbiter: directed scenarios plus randomized transactions
// against a transaction-level winner model.
`default_nettype none

module tb_axi_wr_burst_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arbiter_type = 1'b0;
  logic busy;
  logic timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int lw          = -1;  // index of the previous winner, -1 = none since reset

  axi_wr_burst_arbiter_if #(.NUM(3)) bus ();

  axi_wr_burst_arbiter #(.NUM(3), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arbiter_type (arbiter_type),
    .bus          (bus),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  function automatic int pick(input logic [2:0] req, input logic typ, input int last);
    logic [2:0] r;
    r = req;
    if (typ) begin
      for (int i = 0; i < 3; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_awvalid = 3'b000;
    bus.s_awvalid = 1'b0;
    bus.s_awready = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_wlast   = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_en"},    32'({bus.aw_en, bus.w_en, bus.b_en}), 32'd0);
  endtask

  // Request phase: one edge in IDLE, returns the expected one-hot grant.
  task automatic request(input logic [2:0] req, input logic typ, output logic [2:0] g);
    int w;
    idle_inputs();
    bus.m_awvalid = req;
    arbiter_type  = typ;
    w  = pick(req, typ, lw);
    lw = w;
    g  = 3'b001 << w;
    step();
    chk("grant_at_addr", 32'(bus.grant), 32'(g));
    chk("en_at_addr", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b100);
  endtask

  task automatic aw_handshake(input logic [2:0] g, input bit noisy);
    if (noisy) begin
      bus.m_awvalid = 3'($urandom);
      arbiter_type  = 1'($urandom);
    end
    repeat ($urandom_range(0, 3)) begin
      bus.s_awvalid = 1'($urandom);
      bus.s_awready = ~bus.s_awvalid;
      bus.s_wvalid  = 1'b1;
      bus.s_wready  = 1'b1;
      bus.s_wlast   = 1'b1;
      bus.s_bvalid  = 1'b1;
      bus.s_bready  = 1'b1;
      step();
      chk("addr_stall_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b100);
      chk("addr_stall_grant", 32'(bus.grant), 32'(g));
    end
    bus.s_awvalid = 1'b1;
    bus.s_awready = 1'b1;
    bus.s_wvalid  = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    step();
    chk("data_entry_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b010);
    chk("data_entry_grant", 32'(bus.grant), 32'(g));
  endtask

  task automatic finish_txn(input logic [2:0] g, input int beats, input bit noisy);
    for (int b = 1; b <= beats; b++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.s_awvalid = 1'b1;
        bus.s_awready = 1'b1;
        bus.s_wvalid  = 1'($urandom);
        bus.s_wready  = ~bus.s_wvalid;
        bus.s_wlast   = 1'($urandom);
        bus.s_bvalid  = 1'b1;
        bus.s_bready  = 1'b1;
        step();
        chk("data_stall_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b010);
      end
      if (noisy) begin
        bus.m_awvalid = 3'($urandom);
        arbiter_type  = 1'($urandom);
      end
      bus.s_wvalid = 1'b1;
      bus.s_wready = 1'b1;
      bus.s_wlast  = (b == beats);
      bus.s_bvalid = 1'b0;
      bus.s_bready = 1'b0;
      step();
      chk("beat_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), (b == beats) ? 32'b001 : 32'b010);
      chk("beat_grant", 32'(bus.grant), 32'(g));
    end
    repeat ($urandom_range(0, 3)) begin
      bus.s_wvalid  = 1'b1;
      bus.s_wready  = 1'b1;
      bus.s_wlast   = 1'b1;
      bus.s_bvalid  = 1'($urandom);
      bus.s_bready  = ~bus.s_bvalid;
      step();
      chk("resp_stall_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b001);
      chk("resp_stall_grant", 32'(bus.grant), 32'(g));
    end
    bus.s_bvalid = 1'b1;
    bus.s_bready = 1'b1;
    step();
    check_idle("after_b");
    idle_inputs();
  endtask

  task automatic txn(input logic [2:0] req, input logic typ, input int beats, input bit noisy);
    logic [2:0] g;
    request(req, typ, g);
    aw_handshake(g, noisy);
    finish_txn(g, beats, noisy);
  endtask

  initial begin
    logic [2:0] g;
    logic [2:0] r;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("post_reset_idle");

    // Single master, 4 beats.
    txn(3'b001, 1'b0, 4, 1'b0);

    // Round robin with all requesting: 1,2,0 after master 0, then 1 again.
    for (int i = 0; i < 4; i++) txn(3'b111, 1'b0, 1 + i, 1'b0);

    // Fixed priority.
    txn(3'b110, 1'b1, 2, 1'b0);
    txn(3'b111, 1'b1, 1, 1'b0);

    // Mid-burst changes to arbiter_type and m_awvalid are ignored.
    txn(3'b001, 1'b1, 3, 1'b1);

    // Reset during DATA of a master-1 transaction.
    request(3'b010, 1'b1, g);
    aw_handshake(g, 1'b0);
    rst = 1'b1;
    bus.m_awvalid = 3'b110;
    step();
    check_idle("reset_mid_burst");
    lw  = -1;
    rst = 1'b0;
    txn(3'b110, 1'b0, 2, 1'b0);

    // Stalled W phase.
    request(3'b001, 1'b1, g);
    aw_handshake(g, 1'b0);
    bus.s_awvalid = 1'b0;
    bus.s_awready = 1'b0;
    bus.s_wvalid  = 1'b1;
    bus.s_wready  = 1'b0;
`ifdef WR_WATCHDOG_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("wd_pulse", 32'(timeout_err), (i == 8) ? 32'd1 : 32'd0);
      chk("wd_busy", 32'(busy), (i == 8) ? 32'd0 : 32'd1);
    end
    chk("wd_grant_cleared", 32'(bus.grant), 32'd0);
    idle_inputs();
    step();
    chk("wd_pulse_single", 32'(timeout_err), 32'd0);
    check_idle("wd_idle");
`else
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("no_wd_pulse", 32'(timeout_err), 32'd0);
      chk("no_wd_en", 32'({bus.aw_en, bus.w_en, bus.b_en}), 32'b010);
    end
    finish_txn(g, 1, 1'b0);
`endif

    // Randomized transactions against the winner model.
    for (int n = 0; n < 40; n++) begin
      r = 3'($urandom_range(1, 7));
      txn(r, 1'($urandom), $urandom_range(1, 4), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
